aud_adc_i2s_rx: RTL and testbench



---
 rtl/aud_adc_i2s_rx.sv | 252 +++++++++++++++++++++++++
 tb/tb_aud_adc_i2s_rx.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aud_adc_i2s_rx.sv
// -----------------------------------------------------------------------------
// aud_adc_i2s_rx
//
// Stereo serial-audio receiver for the codec ADC path. BCLK, LRCK and DAT are
// oversampled in the clk domain, left/right samples are deserialised MSB-first
// in I2S or left-justified framing, and each completed stereo pair is offered
// on a valid/ready interface. A pair that completes while the previous one is
// still held is dropped and flagged on overrun_o.
//
// Parameters
//   SAMPLE_W  bits kept per channel (8..32); extra slot bits are ignored
//   I2S_MODE  1 = I2S (MSB one BCLK after the LRCK edge)
//             0 = left-justified (MSB on the first BCLK after the LRCK edge)
//
// Optional feature macro
//   AUD_RX_OVF_CNT_EN  when defined, overrun_cnt_o counts overrun pulses and
//                      saturates at 255; when undefined it is tied to 0.
//
// Ports
//   clk            system clock, at least 4x the codec bit clock
//   rst_n          asynchronous active-low reset, clears every flop
//   aud_bclk_i     codec bit clock (asynchronous to clk)
//   aud_adclrck_i  codec frame clock, low = left slot, high = right slot
//   aud_adcdat_i   codec serial data
//   out_valid_o    stereo pair available
//   out_ready_i    consumer accepts the pair when out_valid_o && out_ready_i
//   out_left_o     left sample, two's complement
//   out_right_o    right sample, two's complement
//   overrun_o      one-clk pulse when a completed pair is dropped
//   overrun_cnt_o  saturating dropped-pair count
// -----------------------------------------------------------------------------
module aud_adc_i2s_rx #(
   parameter int SAMPLE_W = 16,
   parameter bit I2S_MODE = 1'b1
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                aud_bclk_i,
   input  logic                aud_adclrck_i,
   input  logic                aud_adcdat_i,
   output logic                out_valid_o,
   input  logic                out_ready_i,
   output logic [SAMPLE_W-1:0] out_left_o,
   output logic [SAMPLE_W-1:0] out_right_o,
   output logic                overrun_o,
   output logic [7:0]          overrun_cnt_o
);

   localparam int CNT_W = $clog2(SAMPLE_W);
   localparam logic [CNT_W-1:0] CNT_TOP = CNT_W'(SAMPLE_W - 1);

   localparam logic [1:0] ST_SYNC  = 2'd0;
   localparam logic [1:0] ST_DELAY = 2'd1;
   localparam logic [1:0] ST_SHIFT = 2'd2;
   localparam logic [1:0] ST_PAD   = 2'd3;

   // ---------------------------------------------------------------------------
   // Input synchronisers. BCLK gets a third stage so its rising edge can be
   // detected; LRCK and DAT are taken from the same stage depth as the BCLK
   // value that produces the strobe, so all three stay aligned.
   // ---------------------------------------------------------------------------
   logic [2:0] bclk_sync_q;
   logic [1:0] lrck_sync_q;
   logic [1:0] dat_sync_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bclk_sync_q <= '0;
         lrck_sync_q <= '0;
         dat_sync_q  <= '0;
      end else begin
         // NOTE: sequential state is always written with non-blocking
         // assignments so every flop samples the pre-edge values.
         bclk_sync_q <= {bclk_sync_q[1:0], aud_bclk_i};
         lrck_sync_q <= {lrck_sync_q[0], aud_adclrck_i};
         dat_sync_q  <= {dat_sync_q[0], aud_adcdat_i};
      end
   end

   logic bclk_rise;
   logic lrck_s;
   logic dat_s;

   assign bclk_rise = bclk_sync_q[1] & ~bclk_sync_q[2];
   assign lrck_s    = lrck_sync_q[1];
   assign dat_s     = dat_sync_q[1];

   // ---------------------------------------------------------------------------
   // Frame state machine and channel registers
   // ---------------------------------------------------------------------------
   logic [1:0]          state_q,     state_d;
   logic [CNT_W-1:0]    cnt_q,       cnt_d;
   logic                chan_q,      chan_d;      // 0 = left slot, 1 = right slot
   logic                lrck_prev_q, lrck_prev_d; // LRCK seen on the previous strobe
   logic [SAMPLE_W-1:0] left_q,      left_d;
   logic [SAMPLE_W-1:0] right_q,     right_d;

   logic lrck_edge;
   logic start_slot;
   logic shift_bit;
   logic publish;

   assign lrck_edge = lrck_s ^ lrck_prev_q;

   always_comb begin
      // NOTE: every signal written here gets a default first, so no path
      // leaves it unassigned and no latch is inferred.
      state_d     = state_q;
      cnt_d       = cnt_q;
      chan_d      = chan_q;
      lrck_prev_d = lrck_prev_q;
      left_d      = left_q;
      right_d     = right_q;
      start_slot  = 1'b0;
      shift_bit   = 1'b0;
      publish     = 1'b0;

      if (bclk_rise) begin
         lrck_prev_d = lrck_s;
         case (state_q)
            // Only a left-slot start (LRCK falling) aligns us to a frame.
            ST_SYNC: start_slot = lrck_edge & ~lrck_s;
            default: begin
               if (lrck_edge) begin
                  start_slot = 1'b1;
                  // A right slot cut short by LRCK falling still completes the
                  // pair; in PAD the pair was already published early.
                  publish = ~lrck_s & chan_q & (state_q != ST_PAD);
               end else begin
                  shift_bit = (state_q != ST_PAD);
               end
            end
         endcase
      end

      if (start_slot) begin
         chan_d = lrck_s;
         cnt_d  = CNT_TOP;
         // Clearing the target register makes the LSBs of a short slot zero.
         if (lrck_s) right_d = '0;
         else        left_d  = '0;
         if (I2S_MODE) begin
            // The strobe that sees the edge still carries the previous LSB.
            state_d = ST_DELAY;
         end else begin
            // Left-justified: the MSB is on this same strobe.
            state_d = ST_SHIFT;
            cnt_d   = CNT_TOP - CNT_W'(1);
            if (lrck_s) right_d[SAMPLE_W-1] = dat_s;
            else        left_d[SAMPLE_W-1]  = dat_s;
         end
      end

      // DELAY has already skipped the stale bit, so its next strobe is the MSB.
      if (shift_bit) begin
         if (chan_q) right_d[cnt_q] = dat_s;
         else        left_d[cnt_q]  = dat_s;
         if (cnt_q == '0) begin
            state_d = ST_PAD;
            cnt_d   = CNT_TOP;
            publish = chan_q;   // early publish on the last right bit
         end else begin
            state_d = ST_SHIFT;
            cnt_d   = cnt_q - CNT_W'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_SYNC;
         cnt_q       <= CNT_TOP;
         chan_q      <= 1'b0;
         lrck_prev_q <= 1'b0;
         left_q      <= '0;
         right_q     <= '0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         chan_q      <= chan_d;
         lrck_prev_q <= lrck_prev_d;
         left_q      <= left_d;
         right_q     <= right_d;
      end
   end

   // ---------------------------------------------------------------------------
   // Output register and handshake. The right sample is taken from right_d so
   // an early publish includes the bit shifted on this very strobe.
   // ---------------------------------------------------------------------------
   logic                out_valid_q, out_valid_d;
   logic [SAMPLE_W-1:0] out_left_q,  out_left_d;
   logic [SAMPLE_W-1:0] out_right_q, out_right_d;
   logic                overrun_q,   overrun_d;

   always_comb begin
      out_valid_d = out_valid_q;
      out_left_d  = out_left_q;
      out_right_d = out_right_q;
      overrun_d   = 1'b0;
      if (publish) begin
         if (!out_valid_q || out_ready_i) begin
            out_valid_d = 1'b1;
            out_left_d  = left_q;
            out_right_d = right_d;
         end else begin
            overrun_d = 1'b1;
         end
      end else if (out_valid_q && out_ready_i) begin
         out_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid_q <= 1'b0;
         out_left_q  <= '0;
         out_right_q <= '0;
         overrun_q   <= 1'b0;
      end else begin
         out_valid_q <= out_valid_d;
         out_left_q  <= out_left_d;
         out_right_q <= out_right_d;
         overrun_q   <= overrun_d;
      end
   end

   assign out_valid_o = out_valid_q;
   assign out_left_o  = out_left_q;
   assign out_right_o = out_right_q;
   assign overrun_o   = overrun_q;

`ifdef AUD_RX_OVF_CNT_EN
   // Counts in step with the overrun pulse; sticks at 255.
   logic [7:0] ovf_cnt_q, ovf_cnt_d;

   always_comb begin
      ovf_cnt_d = ovf_cnt_q;
      if (overrun_d && (ovf_cnt_q != 8'hFF)) ovf_cnt_d = ovf_cnt_q + 8'd1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) ovf_cnt_q <= '0;
      else        ovf_cnt_q <= ovf_cnt_d;
   end

   assign overrun_cnt_o = ovf_cnt_q;
`else
   assign overrun_cnt_o = '0;
`endif

endmodule

// File: tb/tb_aud_adc_i2s_rx.sv
// -----------------------------------------------------------------------------
// tb_aud_adc_i2s_rx
//
// Two receiver instances share the codec pins: dut_a (16-bit, I2S) and dut_b
// (24-bit, left-justified). Only the instance under test is checked at any
// time; every test starts from a reset so the other instance's state is moot.
// clk = 10 ns, BCLK = 80 ns (clk = 8x BCLK). LRCK/DAT change with BCLK low.
// -----------------------------------------------------------------------------
module tb_aud_adc_i2s_rx;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   logic bclk  = 1'b0;
   logic lrck  = 1'b0;
   logic dat   = 1'b0;
   logic ready_a = 1'b0;
   logic ready_b = 1'b0;

   logic        valid_a, overrun_a;
   logic [15:0] left_a, right_a;
   logic [7:0]  cnt_a;
   logic        valid_b, overrun_b;
   logic [23:0] left_b, right_b;
   logic [7:0]  cnt_b;

`ifdef AUD_RX_OVF_CNT_EN
   localparam logic [7:0] EXP_OVF_CNT = 8'd2;
`else
   localparam logic [7:0] EXP_OVF_CNT = 8'd0;
`endif

   always #5 clk = ~clk;

   aud_adc_i2s_rx #(.SAMPLE_W(16), .I2S_MODE(1'b1)) dut_a (
      .clk           (clk),
      .rst_n         (rst_n),
      .aud_bclk_i    (bclk),
      .aud_adclrck_i (lrck),
      .aud_adcdat_i  (dat),
      .out_valid_o   (valid_a),
      .out_ready_i   (ready_a),
      .out_left_o    (left_a),
      .out_right_o   (right_a),
      .overrun_o     (overrun_a),
      .overrun_cnt_o (cnt_a)
   );

   aud_adc_i2s_rx #(.SAMPLE_W(24), .I2S_MODE(1'b0)) dut_b (
      .clk           (clk),
      .rst_n         (rst_n),
      .aud_bclk_i    (bclk),
      .aud_adclrck_i (lrck),
      .aud_adcdat_i  (dat),
      .out_valid_o   (valid_b),
      .out_ready_i   (ready_b),
      .out_left_o    (left_b),
      .out_right_o   (right_b),
      .overrun_o     (overrun_b),
      .overrun_cnt_o (cnt_b)
   );

   // ---------------------------------------------------------------------------
   // Output monitors, sampled on the falling clk edge
   // ---------------------------------------------------------------------------
   logic [31:0] q_a[$];
   logic [47:0] q_b[$];
   int vcyc_a = 0;
   int ovr_a  = 0;

   always @(negedge clk) begin
      if (valid_a) vcyc_a <= vcyc_a + 1;
      if (overrun_a) ovr_a <= ovr_a + 1;
      if (valid_a && ready_a) q_a.push_back({left_a, right_a});
      if (valid_b && ready_b) q_b.push_back({left_b, right_b});
   end

   // ---------------------------------------------------------------------------
   // Checking and stimulus helpers
   // ---------------------------------------------------------------------------
   int n_checks = 0;
   int n_pass   = 0;
   logic prev_bit = 1'b0;   // last data bit of the previous slot (I2S delay)

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      else n_pass++;
   endtask

   task automatic send_bit(input logic lr, input logic d);
      bclk = 1'b0;
      lrck = lr;
      dat  = d;
      #40;
      bclk = 1'b1;
      #40;
   endtask

   // Slot data is left-aligned in w; 'bits' is the slot length in BCLKs.
   task automatic send_slot(input logic lr, input logic [31:0] w, input int bits, input logic i2s);
      for (int k = 0; k < bits; k++) begin
         logic d;
         if (!i2s)        d = w[31-k];
         else if (k == 0) d = prev_bit;
         else             d = w[32-k];
         send_bit(lr, d);
      end
      prev_bit = w[32-bits];
   endtask

   task automatic send_frame(input logic [31:0] l, input logic [31:0] r, input int bits, input logic i2s);
      send_slot(1'b0, l, bits, i2s);
      send_slot(1'b1, r, bits, i2s);
   endtask

   task automatic lead_in(input int n);
      for (int k = 0; k < n; k++) send_bit(1'b1, 1'b0);
      prev_bit = 1'b0;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      #20;
      rst_n = 1'b1;
   endtask

   function automatic logic [31:0] entry_a(input int idx);
      return (q_a.size() > idx) ? q_a[idx] : 32'hxxxx_xxxx;
   endfunction

   function automatic logic [47:0] entry_b(input int idx);
      return (q_b.size() > idx) ? q_b[idx] : 48'hxxxx_xxxx_xxxx;
   endfunction

   typedef struct {
      logic [31:0] l_slot;
      logic [31:0] r_slot;
      logic [15:0] exp_l;
      logic [15:0] exp_r;
   } vec_t;

   vec_t vecs [4];

   initial begin
      int base;
      int v0;
      int o0;

      // 32-bit I2S slots, SAMPLE_W=16: the low 16 slot bits are padding.
      vecs[0] = '{32'hA5C3_0F0F, 32'h5A3C_F0F0, 16'hA5C3, 16'h5A3C};
      vecs[1] = '{32'h8000_FFFF, 32'h0001_0000, 16'h8000, 16'h0001};
      vecs[2] = '{32'hFFFF_0000, 32'h0000_FFFF, 16'hFFFF, 16'h0000};
      vecs[3] = '{32'h1357_9BDF, 32'hECA8_6420, 16'h1357, 16'hECA8};

      // ---- reset state ------------------------------------------------------
      #23;
      check("rst valid_a", 64'(valid_a), 64'd0);
      check("rst left_a",  64'(left_a),  64'd0);
      check("rst right_a", 64'(right_a), 64'd0);
      check("rst overrun_a", 64'(overrun_a), 64'd0);
      check("rst cnt_a",   64'(cnt_a),   64'd0);
      check("rst valid_b", 64'(valid_b), 64'd0);
      @(negedge clk);
      rst_n = 1'b1;

      // ---- I2S basic, table driven -------------------------------------------
      ready_a = 1'b1;
      base = q_a.size();
      v0   = vcyc_a;
      @(negedge clk);
      lead_in(4);
      for (int i = 0; i < 4; i++) begin
         logic [31:0] e;
         send_frame(vecs[i].l_slot, vecs[i].r_slot, 32, 1'b1);
         e = entry_a(base + i);
         check($sformatf("i2s[%0d] count", i), 64'(q_a.size() - base), 64'(i + 1));
         check($sformatf("i2s[%0d] left", i),  64'(e[31:16]), 64'(vecs[i].exp_l));
         check($sformatf("i2s[%0d] right", i), 64'(e[15:0]),  64'(vecs[i].exp_r));
      end
      check("i2s valid cycles", 64'(vcyc_a - v0), 64'd4);

      // ---- left-justified 24-bit, trailing slot bits set ----------------------
      do_reset();
      ready_b = 1'b1;
      base = q_b.size();
      lead_in(3);
      send_frame({24'h800001, 8'hFF}, {24'h7FFFFE, 8'hFF}, 32, 1'b0);
      check("lj24 count", 64'(q_b.size() - base), 64'd1);
      check("lj24 left",  64'(entry_b(base) >> 24),  64'h800001);
      check("lj24 right", 64'(entry_b(base) & 48'hFF_FFFF), 64'h7FFFFE);

      // ---- short 16-bit slot into 24-bit channel ------------------------------
      do_reset();
      base = q_b.size();
      lead_in(3);
      send_frame(32'hFFFF_0000, 32'hFFFF_0000, 16, 1'b0);
      send_bit(1'b0, 1'b0);
      send_bit(1'b0, 1'b0);
      #100;
      check("short count", 64'(q_b.size() - base), 64'd1);
      check("short left",  64'(entry_b(base) >> 24),  64'hFFFF00);
      check("short right", 64'(entry_b(base) & 48'hFF_FFFF), 64'hFFFF00);

      // ---- startup alignment: reset released mid right slot -------------------
      @(negedge clk);
      rst_n = 1'b0;
      ready_a = 1'b1;
      base = q_a.size();
      for (int k = 0; k < 3; k++) send_bit(1'b1, 1'b1);
      rst_n = 1'b1;
      for (int k = 0; k < 10; k++) send_bit(1'b1, 1'b1);
      prev_bit = 1'b1;
      for (int i = 0; i < 3; i++) send_frame(vecs[i].l_slot, vecs[i].r_slot, 32, 1'b1);
      send_bit(1'b0, prev_bit);
      send_bit(1'b0, 1'b0);
      #100;
      check("startup count", 64'(q_a.size() - base), 64'd3);
      for (int i = 0; i < 3; i++)
         check($sformatf("startup[%0d] pair", i), 64'(entry_a(base + i)),
               64'({vecs[i].exp_l, vecs[i].exp_r}));

      // ---- backpressure: first pair held, later pairs dropped -----------------
      do_reset();
      ready_a = 1'b0;
      base = q_a.size();
      o0   = ovr_a;
      lead_in(4);
      send_frame(vecs[0].l_slot, vecs[0].r_slot, 32, 1'b1);
      check("bp first valid", 64'(valid_a), 64'd1);
      check("bp first pair", 64'({left_a, right_a}), 64'h A5C3_5A3C);
      send_frame(vecs[1].l_slot, vecs[1].r_slot, 32, 1'b1);
      check("bp held after 2nd", 64'({left_a, right_a}), 64'hA5C3_5A3C);
      send_frame(vecs[2].l_slot, vecs[2].r_slot, 32, 1'b1);
      send_bit(1'b0, prev_bit);
      send_bit(1'b0, 1'b0);
      #100;
      check("bp held after 3rd", 64'({left_a, right_a}), 64'hA5C3_5A3C);
      check("bp overrun pulses", 64'(ovr_a - o0), 64'd2);
      check("bp overrun_cnt", 64'(cnt_a), 64'(EXP_OVF_CNT));
      check("bp nothing accepted", 64'(q_a.size() - base), 64'd0);
      @(posedge clk);
      #1;
      ready_a = 1'b1;
      repeat (4) @(negedge clk);
      check("bp drain count", 64'(q_a.size() - base), 64'd1);
      check("bp drain pair", 64'(entry_a(base)), 64'hA5C3_5A3C);
      check("bp drained valid", 64'(valid_a), 64'd0);

      // ---- async reset mid SHIFT while a pair is held -------------------------
      do_reset();
      ready_a = 1'b0;
      lead_in(4);
      send_frame(vecs[3].l_slot, vecs[3].r_slot, 32, 1'b1);
      check("ar valid before", 64'(valid_a), 64'd1);
      for (int k = 0; k < 8; k++) send_bit(1'b0, 1'b1);
      #2;
      rst_n = 1'b0;
      #1;
      check("ar valid",   64'(valid_a),   64'd0);
      check("ar left",    64'(left_a),    64'd0);
      check("ar right",   64'(right_a),   64'd0);
      check("ar overrun", 64'(overrun_a), 64'd0);
      check("ar cnt",     64'(cnt_a),     64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      ready_a = 1'b1;
      base = q_a.size();
      for (int k = 0; k < 20; k++) send_bit(1'b0, 1'b1);
      for (int k = 0; k < 32; k++) send_bit(1'b1, 1'b1);
      check("ar no partial pair", 64'(q_a.size() - base), 64'd0);
      prev_bit = 1'b1;
      send_frame(vecs[1].l_slot, vecs[1].r_slot, 32, 1'b1);
      send_bit(1'b0, prev_bit);
      #100;
      check("ar resync count", 64'(q_a.size() - base), 64'd1);
      check("ar resync pair", 64'(entry_a(base)), 64'h8000_0001);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
